// File: rtl/ppu_fb_writer.sv
// PPU pixel stream to double-buffered frame memory writer.
// Tracks raster position, buffers pixels in a FIFO and publishes the last completed bank.
module ppu_fb_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int H_PIX      = 256,
  parameter int V_PIX      = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        px_en,
  input  logic [7:0]  px_data,
  input  logic        frame_sync,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [16:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        disp_bank,
  output logic        frame_done,
  input  logic        err_clr,
  output logic        ovf_err,
  output logic        extra_err,
  output logic        short_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] X_LAST = 8'(H_PIX - 1);
  localparam logic [7:0] Y_LAST = 8'(V_PIX - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_DONE     = 2'd2
  } pos_state_t;

  pos_state_t  state_q, state_d, eff_state;
  logic [7:0]  x_q, y_q, cur_x, cur_y;
  logic        bank_q, cur_bank, last_pushed_q;
  logic        accept, extra_px, is_last, push, pop, full, empty, ovf_set, short_set;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [25:0] mem [FIFO_DEPTH];
  logic [25:0] head;

  // A sync in the same cycle as px_en is applied first, so the pixel lands at (0,0) of the new bank.
  always_comb begin
    eff_state = state_q;
    cur_x     = x_q;
    cur_y     = y_q;
    cur_bank  = bank_q;
    if (frame_sync) begin
      eff_state = ST_ACTIVE;
      cur_x     = 8'd0;
      cur_y     = 8'd0;
      cur_bank  = ~bank_q;
    end
    accept   = px_en && (eff_state == ST_ACTIVE);
    extra_px = px_en && (eff_state == ST_DONE);
    is_last  = (cur_x == X_LAST) && (cur_y == Y_LAST);
    state_d  = eff_state;
    if (accept && is_last) state_d = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_DISARMED;
    else     state_q <= state_d;
  end

  assign dbg_state = state_q;

  // Position advances even when the FIFO drops the pixel, keeping later addresses correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= 8'd0;
      y_q           <= 8'd0;
      bank_q        <= 1'b0;
      last_pushed_q <= 1'b0;
    end else begin
      if (frame_sync) begin
        bank_q        <= ~bank_q;
        last_pushed_q <= 1'b0;
      end
      if (accept) begin
        if (cur_x == X_LAST) begin
          x_q <= 8'd0;
          y_q <= cur_y + 8'd1;
        end else begin
          x_q <= cur_x + 8'd1;
          y_q <= cur_y;
        end
      end else if (frame_sync) begin
        x_q <= 8'd0;
        y_q <= 8'd0;
      end
      if (push && is_last) last_pushed_q <= 1'b1;
    end
  end

  // Handshake: fb_valid/fb_addr/fb_data hold until a cycle with fb_valid && fb_ready, where the
  // head transfers; the next entry (if any) is presented the following cycle.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = fb_valid && fb_ready;
  assign push  = accept && (!full || pop);
  assign ovf_set   = accept && full && !pop;
  assign short_set = frame_sync && (state_q != ST_DISARMED) && !last_pushed_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cur_bank, cur_y, cur_x, px_data, is_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign fb_valid = !empty;
  assign fb_addr  = empty ? 17'd0 : head[25:9];
  assign fb_data  = empty ? 8'd0 : head[8:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bank  <= 1'b1;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
      extra_err  <= 1'b0;
      short_err  <= 1'b0;
    end else begin
      frame_done <= pop && head[0];
      if (pop && head[0]) disp_bank <= head[25];
      ovf_err   <= ovf_set   || (ovf_err   && !err_clr);
      extra_err <= extra_px  || (extra_err && !err_clr);
      short_err <= short_set || (short_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench for ppu_fb_writer: per-cycle vector table plus multi-cycle frame sequences
// checked against an expected-transfer queue.
module tb_ppu_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        px_en = 1'b0;
  logic [7:0]  px_data = 8'd0;
  logic        frame_sync = 1'b0;
  logic        fb_valid;
  logic        fb_ready = 1'b0;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic        disp_bank;
  logic        frame_done;
  logic        err_clr = 1'b0;
  logic        ovf_err;
  logic        extra_err;
  logic        short_err;
  logic [1:0]  dbg_state;

  ppu_fb_writer dut (
    .clk(clk), .rst(rst), .px_en(px_en), .px_data(px_data), .frame_sync(frame_sync),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .disp_bank(disp_bank), .frame_done(frame_done), .err_clr(err_clr),
    .ovf_err(ovf_err), .extra_err(extra_err), .short_err(short_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic        sb_en = 1'b0;
  logic [16:0] last_addr = 17'd0;
  logic [24:0] exp_q[$];

  typedef struct {
    logic        sync, en;
    logic [7:0]  data;
    logic        ready, clr;
    logic        exp_valid;
    logic [16:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_done, exp_disp, exp_ovf, exp_extra, exp_short;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs; any transfer at the coming edge is checked against exp_q.
  task automatic step(input logic s, input logic e, input logic [7:0] d,
                      input logic r, input logic c);
    logic [24:0] ent;
    frame_sync = s; px_en = e; px_data = d; fb_ready = r; err_clr = c;
    if (sb_en && fb_valid && fb_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected: got transfer addr 0x%0h data 0x%0h expected none", fb_addr, fb_data);
      end else begin
        ent = exp_q.pop_front();
        check("sb_addr", 32'(fb_addr), 32'(ent[24:8]));
        check("sb_data", 32'(fb_data), 32'(ent[7:0]));
        last_addr = fb_addr;
      end
    end
    @(posedge clk);
    #1;
    if (frame_done) done_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 64) begin
      step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      n++;
    end
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic add_vec(input logic s, input logic e, input logic [7:0] d, input logic r,
                         input logic c, input logic ev, input logic [16:0] ea,
                         input logic [7:0] ed, input logic edn, input logic eds,
                         input logic eo, input logic ee, input logic es);
    vec_t v;
    v.sync = s; v.en = e; v.data = d; v.ready = r; v.clr = c;
    v.exp_valid = ev; v.exp_addr = ea; v.exp_data = ed; v.exp_done = edn; v.exp_disp = eds;
    v.exp_ovf = eo; v.exp_extra = ee; v.exp_short = es;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_valid", 32'(fb_valid), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_data", 32'(fb_data), 32'd0);
    check("rst_disp", 32'(disp_bank), 32'd1);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_errs", 32'({ovf_err, extra_err, short_err}), 32'd0);

    //        sync en  data   rdy clr  valid addr      data   done disp ovf ext sht
    for (int i = 0; i < 10; i++)
      add_vec(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 17'h0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 17'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b1, 17'h10000, 8'h2A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 17'h10000, 8'h2A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 17'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 17'h00000, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 17'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 17'h00001, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 17'h00001, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 17'h10000, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 17'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sync, vecs[i].en, vecs[i].data, vecs[i].ready, vecs[i].clr);
      check($sformatf("vec%0d_valid", i), 32'(fb_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_addr", i), 32'(fb_addr), 32'(vecs[i].exp_addr));
        check($sformatf("vec%0d_data", i), 32'(fb_data), 32'(vecs[i].exp_data));
      end
      check($sformatf("vec%0d_done", i), 32'(frame_done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_disp", i), 32'(disp_bank), 32'(vecs[i].exp_disp));
      check($sformatf("vec%0d_errs", i), 32'({ovf_err, extra_err, short_err}),
            32'({vecs[i].exp_ovf, vecs[i].exp_extra, vecs[i].exp_short}));
    end

    // Full frame in bank 1, raster order, one frame_done
    do_reset();
    sb_en = 1'b1;
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    for (int y = 0; y < 240; y++) begin
      for (int x = 0; x < 256; x++) begin
        logic [7:0] d;
        d = 8'(x ^ (y * 3));
        exp_q.push_back({1'b1, 8'(y), 8'(x), d});
        step(1'b0, 1'b1, d, 1'b1, 1'b0);
      end
    end
    drain();
    check("frame_last_addr", 32'(last_addr), 32'h1EFFF);
    check("frame_done_cnt", 32'(done_cnt), 32'd1);
    check("frame_disp", 32'(disp_bank), 32'd1);
    check("frame_errs", 32'({ovf_err, extra_err, short_err}), 32'd0);

    // Extra pixel after the last one, then clear, then clear colliding with a new extra pixel
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    check("extra_set", 32'(extra_err), 32'd1);
    check("extra_dropped", 32'(fb_valid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("extra_clr", 32'(extra_err), 32'd0);
    step(1'b0, 1'b1, 8'hBB, 1'b1, 1'b1);
    check("extra_set_wins", 32'(extra_err), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("complete_no_short", 32'(short_err), 32'd0);
    exp_q.push_back({1'b0, 8'd0, 8'd0, 8'h11});
    step(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    drain();

    // Overflow: 20 pixels while stalled, 16 kept, x=16..19 lost, next pixel at x=20
    do_reset();
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back({1'b1, 8'd0, 8'(i), 8'(i + 1)});
      step(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b0);
      check($sformatf("stall_hold%0d", i), 32'({fb_valid, fb_addr}), 32'({1'b1, 17'h10000}));
    end
    check("ovf_set", 32'(ovf_err), 32'd1);
    exp_q.push_back({1'b1, 8'd0, 8'd20, 8'hC8});
    step(1'b0, 1'b1, 8'hC8, 1'b1, 1'b0);
    drain();
    check("ovf_sticky", 32'(ovf_err), 32'd1);

    // Short frame: sync at x=5,y=3
    do_reset();
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3 * 256 + 5; i++) begin
      exp_q.push_back({1'b1, 8'(i / 256), 8'(i % 256), 8'(i)});
      step(1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    check("short_set", 32'(short_err), 32'd1);
    exp_q.push_back({1'b0, 8'd0, 8'd0, 8'h3C});
    step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    drain();
    check("short_disp", 32'(disp_bank), 32'd1);
    check("short_no_done", 32'(done_cnt), 32'd0);

    // Reset while a write is stalled
    sb_en = 1'b0;
    do_reset();
    step(1'b1, 1'b1, 8'h9E, 1'b0, 1'b0);
    check("stall_valid", 32'({fb_valid, fb_addr, fb_data}), 32'({1'b1, 17'h10000, 8'h9E}));
    rst = 1'b1;
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_mid_valid", 32'(fb_valid), 32'd0);
    check("rst_mid_disp", 32'(disp_bank), 32'd1);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("rst_mid_empty", 32'(fb_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
